bus_fifo_device: RTL and testbench

Memory-mapped FIFO mailbox peripheral on the device (responder) side of the simple Ibex bus. Host writes to a DATA register push words into a TX FIFO drained by a valid/ready stream output. Host reads of DATA pop words from an RX FIFO filled by a valid/ready stream input. Every request is answered exactly one cycle later, as the bus requires of all devices.

---
 rtl/bus_fifo_device_pkg.sv | 19 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/bus_fifo_device.sv | 119 +++++++++++
 tb/tb_bus_fifo_device.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_fifo_device_pkg.sv
// Register map and field positions shared by the FIFO mailbox peripheral.
package bus_fifo_device_pkg;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;

    localparam int StatusTxEmpty    = 0;
    localparam int StatusTxFull     = 1;
    localparam int StatusRxEmpty    = 2;
    localparam int StatusRxFull     = 3;
    localparam int StatusTxLevelLsb = 8;
    localparam int StatusRxLevelLsb = 16;
    localparam int StatusLevelBits  = 8;

    localparam int CtrlFlushTx = 0;
    localparam int CtrlFlushRx = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, level tracking and a head word read straight from storage flops.
module sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [Width-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int LevelWidth = PtrWidth + 1;

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Flush wins over any transfer presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LevelWidth'(1);
                2'b01:   level <= level - LevelWidth'(1);
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LevelWidth'(Depth));
    assign empty = (level == '0);

endmodule

// File: rtl/bus_fifo_device.sv
// Bus-mapped mailbox: DATA writes feed the TX stream, DATA reads drain the RX stream.
module bus_fifo_device
    import bus_fifo_device_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int Depth        = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [DataWidth/8-1:0]  device_be_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    device_err_o,
    output logic                    tx_valid_o,
    output logic [DataWidth-1:0]    tx_data_o,
    input  logic                    tx_ready_i,
    input  logic                    rx_valid_i,
    input  logic [DataWidth-1:0]    rx_data_i,
    output logic                    rx_ready_o
);

    localparam int LevelWidth = $clog2(Depth) + 1;

    logic [1:0]            reg_idx;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [LevelWidth-1:0] tx_level, rx_level;
    logic [DataWidth-1:0]  rx_head;
    logic                  access_err;
    logic                  tx_push, rx_pop, ctrl_wr;
    logic [DataWidth-1:0]  status;
    logic [DataWidth-1:0]  rdata_next;
    logic                  unused_addr;

    assign reg_idx     = device_addr_i[3:2];
    assign unused_addr = ^{device_addr_i[AddressWidth-1:4], device_addr_i[1:0]};

    // Full/empty come from registered state, so a same-cycle stream transfer cannot rescue an access.
    always_comb begin
        access_err = 1'b0;
        case (reg_idx)
            RegData:   access_err = device_we_i ? (tx_full || !(&device_be_i)) : rx_empty;
            RegStatus: access_err = device_we_i;
            RegCtrl:   access_err = 1'b0;
            default:   access_err = 1'b1;
        endcase
    end

    assign tx_push = device_req_i && device_we_i && (reg_idx == RegData) && !access_err;
    assign rx_pop  = device_req_i && !device_we_i && (reg_idx == RegData) && !access_err;
    assign ctrl_wr = device_req_i && device_we_i && (reg_idx == RegCtrl);

    always_comb begin
        status = '0;
        status[StatusTxEmpty] = tx_empty;
        status[StatusTxFull]  = tx_full;
        status[StatusRxEmpty] = rx_empty;
        status[StatusRxFull]  = rx_full;
        status[StatusTxLevelLsb +: StatusLevelBits] = StatusLevelBits'(tx_level);
        status[StatusRxLevelLsb +: StatusLevelBits] = StatusLevelBits'(rx_level);
    end

    always_comb begin
        rdata_next = '0;
        if (!device_we_i && !access_err) begin
            case (reg_idx)
                RegData:   rdata_next = rx_head;
                RegStatus: rdata_next = status;
                default:   rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            device_rvalid_o <= 1'b0;
            device_err_o    <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_err_o    <= device_req_i && access_err;
            device_rdata_o  <= device_req_i ? rdata_next : '0;
        end
    end

    assign tx_valid_o = !tx_empty;
    assign rx_ready_o = !rx_full;

    sync_fifo #(.Width(DataWidth), .Depth(Depth)) u_tx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (tx_push),
        .push_data (device_wdata_i),
        .pop       (tx_valid_o && tx_ready_i),
        .flush     (ctrl_wr && device_wdata_i[CtrlFlushTx]),
        .head      (tx_data_o),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sync_fifo #(.Width(DataWidth), .Depth(Depth)) u_rx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (rx_valid_i && rx_ready_o),
        .push_data (rx_data_i),
        .pop       (rx_pop),
        .flush     (ctrl_wr && device_wdata_i[CtrlFlushRx]),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

endmodule

// File: tb/tb_bus_fifo_device.sv
// Directed bench for the FIFO mailbox: table of bus/stream vectors plus hand sequences for drains and reset.
module tb_bus_fifo_device;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        bit          req;
        bit          we;
        bit [1:0]    idx;
        bit [3:0]    be;
        bit [31:0]   wdata;
        bit          tx_ready;
        bit          rx_valid;
        bit [31:0]   rx_data;
        bit          exp_err;
        bit [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[$];

    bus_fifo_device dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .device_err_o    (err),
        .tx_valid_o      (tx_valid),
        .tx_data_o       (tx_data),
        .tx_ready_i      (tx_ready),
        .rx_valid_i      (rx_valid),
        .rx_data_i       (rx_data),
        .rx_ready_o      (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input bit rq, input bit w, input bit [1:0] idx,
                                input bit [3:0] b, input bit [31:0] wd, input bit txr, input bit rxv,
                                input bit [31:0] rxd, input bit e, input bit [31:0] rd);
        vecs.push_back('{name, rq, w, idx, b, wd, txr, rxv, rxd, e, rd});
    endfunction

    function automatic void wr(input string name, input bit [1:0] idx, input bit [31:0] wd, input bit e);
        add(name, 1, 1, idx, 4'hF, wd, 0, 0, 0, e, 0);
    endfunction

    function automatic void rd(input string name, input bit [1:0] idx, input bit e, input bit [31:0] v);
        add(name, 1, 0, idx, 4'hF, 0, 0, 0, 0, e, v);
    endfunction

    function automatic void push(input string name, input bit [31:0] d);
        add(name, 0, 0, 0, 0, 0, 0, 1, d, 0, 0);
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req      = vecs[i].req;
            we       = vecs[i].we;
            addr     = {28'd0, vecs[i].idx, 2'b00};
            be       = vecs[i].be;
            wdata    = vecs[i].wdata;
            tx_ready = vecs[i].tx_ready;
            rx_valid = vecs[i].rx_valid;
            rx_data  = vecs[i].rx_data;
            @(posedge clk);
            #1;
            chk({vecs[i].name, " rvalid"}, {31'd0, rvalid}, {31'd0, vecs[i].req});
            if (vecs[i].req) begin
                chk({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
                chk({vecs[i].name, " rdata"}, rdata, vecs[i].exp_rdata);
            end
            req = 1'b0;
            tx_ready = 1'b0;
            rx_valid = 1'b0;
        end
        vecs.delete();
    endtask

    task automatic drain_tx(input string name, input logic [31:0] first, input int count);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            chk($sformatf("%s valid %0d", name, i), {31'd0, tx_valid}, 32'd1);
            chk($sformatf("%s data %0d", name, i), tx_data, first + 32'(i));
            @(negedge clk);
        end
        chk({name, " empty after drain"}, {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset tx_data", tx_data, 32'd0);
        chk("reset rx_ready", {31'd0, rx_ready}, 32'd1);
        rst = 1'b0;

        // TX fill, overflow and register-map errors
        rd("status after reset", 2'd1, 0, 32'h0000_0005);
        for (int k = 1; k <= 8; k++) wr($sformatf("tx write %0d", k), 2'd0, 32'hA5A5_0000 + 32'(k), 0);
        wr("tx write overflow", 2'd0, 32'hA5A5_0009, 1);
        rd("status tx full", 2'd1, 0, 32'h0000_0806);
        wr("status write", 2'd1, 32'hFFFF_FFFF, 1);
        rd("reserved read", 2'd3, 1, 32'h0);
        wr("reserved write", 2'd3, 32'h1234_5678, 1);
        rd("ctrl read", 2'd2, 0, 32'h0);
        add("idle cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs();
        drain_tx("tx drain", 32'hA5A5_0001, 8);

        // RX push/read, underflow, simultaneous push+pop
        push("rx push 11", 32'h11);
        push("rx push 22", 32'h22);
        push("rx push 33", 32'h33);
        rd("rx read 1", 2'd0, 0, 32'h11);
        rd("rx read 2", 2'd0, 0, 32'h22);
        rd("rx read 3", 2'd0, 0, 32'h33);
        rd("rx read empty", 2'd0, 1, 32'h0);
        push("rx push 55", 32'h55);
        add("rx read with push", 1, 0, 0, 4'hF, 0, 0, 1, 32'h66, 0, 32'h55);
        rd("status rx level 1", 2'd1, 0, 32'h0001_0001);
        rd("rx read 66", 2'd0, 0, 32'h66);
        add("rx empty read with push", 1, 0, 0, 4'hF, 0, 0, 1, 32'h77, 1, 32'h0);
        rd("rx read 77", 2'd0, 0, 32'h77);
        run_vecs();

        // TX full rejects a write even while the stream pops
        for (int k = 1; k <= 8; k++) wr($sformatf("tx refill %0d", k), 2'd0, 32'hC0DE_0000 + 32'(k), 0);
        add("tx write full with pop", 1, 1, 0, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 1, 32'h0);
        rd("status tx level 7", 2'd1, 0, 32'h0000_0704);
        run_vecs();
        drain_tx("tx drain after pop", 32'hC0DE_0002, 7);

        // Flushes
        for (int k = 1; k <= 5; k++) push($sformatf("rx fill %0d", k), 32'h100 + 32'(k));
        rd("status rx level 5", 2'd1, 0, 32'h0005_0001);
        add("ctrl flush rx with push", 1, 1, 2'd2, 4'hF, 32'h2, 0, 1, 32'h999, 0, 32'h0);
        rd("status after rx flush", 2'd1, 0, 32'h0000_0005);
        rd("rx read after flush", 2'd0, 1, 32'h0);
        wr("tx write a", 2'd0, 32'h0000_00AA, 0);
        wr("tx write b", 2'd0, 32'h0000_00BB, 0);
        wr("ctrl flush tx", 2'd2, 32'h1, 0);
        rd("status after tx flush", 2'd1, 0, 32'h0000_0005);
        for (int k = 1; k <= 8; k++) push($sformatf("rx full fill %0d", k), 32'h200 + 32'(k));
        push("rx push while full", 32'h2FF);
        rd("status rx full", 2'd1, 0, 32'h0008_0009);
        run_vecs();
        chk("rx_ready when full", {31'd0, rx_ready}, 32'd0);
        rd("rx read head when full", 2'd0, 0, 32'h201);
        wr("ctrl flush both", 2'd2, 32'h3, 0);
        rd("status after flush both", 2'd1, 0, 32'h0000_0005);
        run_vecs();
        chk("rx_ready after flush", {31'd0, rx_ready}, 32'd1);

        // Reset lands between a DATA write request and its response
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h5555_AAAA;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset drops response", {31'd0, rvalid}, 32'd0);
        chk("reset empties tx", {31'd0, tx_valid}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        add("partial be write", 1, 1, 0, 4'h3, 32'h1111_2222, 0, 0, 0, 1, 32'h0);
        rd("status after reset mid-op", 2'd1, 0, 32'h0000_0005);
        run_vecs();
        chk("tx stays empty", {31'd0, tx_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
